regfile_read_scoreboard: RTL and testbench

//  Read side of the CPU register file: two read ports behind a valid/ready handshake from decode,

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_entry.sv | 27 ++
 rtl/regfile_read_scoreboard.sv | 93 +++++++++
 tb/tb_regfile_read_scoreboard.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizing constants and types for the register-file read/scoreboard slice.
package regfile_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/regfile_entry.sv
// One architectural register: storage word plus in-flight-write busy bit.
import regfile_pkg::*;

module regfile_entry (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      wr_en,
  input  reg_data_t wr_data,
  input  logic      busy_set,
  input  logic      busy_clr,
  output reg_data_t data,
  output logic      busy
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= '0;
      busy <= 1'b0;
    end else begin
      if (wr_en) data <= wr_data;
      // A new writer claiming the register outranks the old writer retiring.
      if (busy_set)      busy <= 1'b1;
      else if (busy_clr) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_read_scoreboard.sv
// Dual read port register file with busy-bit scoreboard and writeback bypass.
import regfile_pkg::*;

module regfile_read_scoreboard (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      rd_valid,
  output logic      rd_ready,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  input  logic      rd_dest_en,
  input  reg_addr_t rd_dest,
  output reg_data_t rd_data_a,
  output reg_data_t rd_data_b,
  output logic      rd_data_vld,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  reg_data_t wr_data
);

  reg_data_t        word_arr [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] busy_set;
  logic [NREGS-1:0] eff_busy;
  logic             accept;
  reg_data_t        data_a_next;
  reg_data_t        data_b_next;
  reg_data_t        data_a_reg;
  reg_data_t        data_b_reg;
  logic             vld_reg;

  assign eff_busy = busy_vec & ~wr_hit;
  assign rd_ready = ~eff_busy[rd_addr_a] & ~eff_busy[rd_addr_b] &
                    ~(rd_dest_en & eff_busy[rd_dest]);
  assign accept   = rd_valid & rd_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      assign wr_hit[gi]   = wr_en & (wr_addr == reg_addr_t'(gi));
      assign busy_set[gi] = accept & rd_dest_en & (rd_dest == reg_addr_t'(gi));
      if (gi == ZERO_REG) begin : g_zero
        // XZR has no storage: always zero and never tracked as busy.
        assign word_arr[gi] = '0;
        assign busy_vec[gi] = 1'b0;
      end else begin : g_entry
        regfile_entry u_entry (
          .clk      (clk),
          .reset_n  (reset_n),
          .wr_en    (wr_hit[gi]),
          .wr_data  (wr_data),
          .busy_set (busy_set[gi]),
          .busy_clr (wr_hit[gi]),
          .data     (word_arr[gi]),
          .busy     (busy_vec[gi])
        );
      end
    end
  endgenerate

  function automatic reg_data_t read_port(input reg_addr_t addr);
    if (addr == reg_addr_t'(ZERO_REG))  return '0;
    else if (wr_en && wr_addr == addr)  return wr_data;
    else                                return word_arr[addr];
  endfunction

  always_comb begin
    data_a_next = data_a_reg;
    data_b_next = data_b_reg;
    if (accept) begin
      data_a_next = read_port(rd_addr_a);
      data_b_next = read_port(rd_addr_b);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_a_reg <= '0;
      data_b_reg <= '0;
      vld_reg    <= 1'b0;
    end else begin
      data_a_reg <= data_a_next;
      data_b_reg <= data_b_next;
      vld_reg    <= accept;
    end
  end

  assign rd_data_a   = data_a_reg;
  assign rd_data_b   = data_b_reg;
  assign rd_data_vld = vld_reg;

endmodule

// File: tb/tb_regfile_read_scoreboard.sv
// Directed vector bench for regfile_read_scoreboard: hazards, bypass, XZR and reset.
import regfile_pkg::*;

module tb_regfile_read_scoreboard;

  logic      clk = 1'b0;
  logic      reset_n;
  logic      rd_valid;
  logic      rd_ready;
  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  logic      rd_dest_en;
  reg_addr_t rd_dest;
  reg_data_t rd_data_a;
  reg_data_t rd_data_b;
  logic      rd_data_vld;
  logic      wr_en;
  reg_addr_t wr_addr;
  reg_data_t wr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_read_scoreboard dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_dest_en  (rd_dest_en),
    .rd_dest     (rd_dest),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .rd_data_vld (rd_data_vld),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data)
  );

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        valid;
    logic [4:0]  a;
    logic [4:0]  b;
    logic        den;
    logic [4:0]  dest;
    logic        exp_ready;
    logic        exp_vld;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_valid = 1'b0; rd_addr_a = '0; rd_addr_b = '0; rd_dest_en = 1'b0; rd_dest = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  function automatic vec_t mk(input logic wen, input logic [4:0] waddr, input logic [63:0] wdata,
                              input logic valid, input logic [4:0] a, input logic [4:0] b,
                              input logic den, input logic [4:0] dest, input logic exp_ready,
                              input logic exp_vld, input logic [63:0] exp_a,
                              input logic [63:0] exp_b);
    vec_t v;
    v.wen = wen; v.waddr = waddr; v.wdata = wdata; v.valid = valid; v.a = a; v.b = b;
    v.den = den; v.dest = dest; v.exp_ready = exp_ready; v.exp_vld = exp_vld;
    v.exp_a = exp_a; v.exp_b = exp_b;
    return v;
  endfunction

  initial begin
    //           wen waddr wdata    vld a   b   den dest rdy vld exp_a    exp_b
    vecs[0]  = mk(0, 0,  64'h0,    1,  5,  6,  0,  0,   1,  1,  64'h0,    64'h0);
    vecs[1]  = mk(1, 3,  64'hDEAD, 0,  0,  0,  0,  0,   1,  0,  64'h0,    64'h0);
    vecs[2]  = mk(0, 0,  64'h0,    1,  3,  31, 0,  0,   1,  1,  64'hDEAD, 64'h0);
    vecs[3]  = mk(0, 0,  64'h0,    1,  1,  2,  1,  7,   1,  1,  64'h0,    64'h0);
    vecs[4]  = mk(0, 0,  64'h0,    1,  7,  0,  0,  0,   0,  0,  64'h0,    64'h0);
    vecs[5]  = mk(0, 0,  64'h0,    1,  7,  0,  0,  0,   0,  0,  64'h0,    64'h0);
    vecs[6]  = mk(0, 0,  64'h0,    1,  7,  0,  0,  0,   0,  0,  64'h0,    64'h0);
    vecs[7]  = mk(1, 7,  64'h55,   1,  7,  0,  0,  0,   1,  1,  64'h55,   64'h0);
    vecs[8]  = mk(0, 0,  64'h0,    1,  7,  7,  0,  0,   1,  1,  64'h55,   64'h55);
    vecs[9]  = mk(0, 0,  64'h0,    1,  0,  0,  1,  9,   1,  1,  64'h0,    64'h0);
    vecs[10] = mk(0, 0,  64'h0,    1,  0,  0,  1,  9,   0,  0,  64'h0,    64'h0);
    vecs[11] = mk(1, 9,  64'h99,   1,  0,  0,  1,  9,   1,  1,  64'h0,    64'h0);
    vecs[12] = mk(0, 0,  64'h0,    1,  9,  0,  0,  0,   0,  0,  64'h0,    64'h0);
    vecs[13] = mk(1, 9,  64'h1234, 1,  9,  9,  0,  0,   1,  1,  64'h1234, 64'h1234);
    vecs[14] = mk(0, 0,  64'h0,    1,  0,  0,  1,  31,  1,  1,  64'h0,    64'h0);
    vecs[15] = mk(0, 0,  64'h0,    1,  31, 31, 0,  0,   1,  1,  64'h0,    64'h0);
    vecs[16] = mk(1, 31, 64'hFF,   0,  31, 0,  0,  0,   1,  0,  64'h0,    64'h0);
    vecs[17] = mk(0, 0,  64'h0,    1,  31, 3,  0,  0,   1,  1,  64'h0,    64'hDEAD);

    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vld", 64'(rd_data_vld), 64'h0);
    chk("reset_a", rd_data_a, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset_ready", 64'(rd_ready), 64'h1);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      wr_en = vecs[i].wen; wr_addr = vecs[i].waddr; wr_data = vecs[i].wdata;
      rd_valid = vecs[i].valid; rd_addr_a = vecs[i].a; rd_addr_b = vecs[i].b;
      rd_dest_en = vecs[i].den; rd_dest = vecs[i].dest;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(rd_ready), 64'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_vld", i), 64'(rd_data_vld), 64'(vecs[i].exp_vld));
      chk($sformatf("v%0d_a", i), rd_data_a, vecs[i].exp_a);
      chk($sformatf("v%0d_b", i), rd_data_b, vecs[i].exp_b);
      $display("vec %0d: ready=%0b vld=%0b a=0x%0h b=0x%0h", i, rd_ready, rd_data_vld,
               rd_data_a, rd_data_b);
    end

    // Accept marks X12 busy, then reset lands before the data cycle can be used.
    @(negedge clk);
    idle_inputs();
    rd_valid = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd3; rd_dest_en = 1'b1; rd_dest = 5'd12;
    #1;
    chk("rst_mid_ready", 64'(rd_ready), 64'h1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_vld", 64'(rd_data_vld), 64'h0);
    chk("rst_mid_a", rd_data_a, 64'h0);
    @(negedge clk);
    idle_inputs();
    rd_addr_a = 5'd12; rd_addr_b = 5'd12; rd_dest_en = 1'b1; rd_dest = 5'd12;
    reset_n = 1'b1;
    #1;
    chk("rst_busy_cleared", 64'(rd_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("rst_no_vld", 64'(rd_data_vld), 64'h0);
    @(negedge clk);
    idle_inputs();
    rd_valid = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd9;
    @(posedge clk);
    #1;
    chk("rst_vld_after", 64'(rd_data_vld), 64'h1);
    chk("rst_x3_zero", rd_data_a, 64'h0);
    chk("rst_x9_zero", rd_data_b, 64'h0);
    $display("reset seq: vld=%0b a=0x%0h b=0x%0h", rd_data_vld, rd_data_a, rd_data_b);

    @(negedge clk);
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
